// File: rtl/rom_arb_pkg.sv
// Shared types and the round-robin select helper for the rom read-port arbiter.
package rom_arb_pkg;

  localparam int unsigned N_REQ_MAX = 8;
  localparam int unsigned W_TAG     = $clog2(N_REQ_MAX);

  typedef logic [W_TAG-1:0] tag_t;

  typedef enum logic {
    GRANT_IDLE,
    GRANT_LOCKED
  } grant_state_e;

  typedef struct packed {
    logic found;
    tag_t idx;
  } rr_sel_t;

  // First set bit of req at or after start, wrapping within the low n bits.
  function automatic rr_sel_t rr_select(input logic [N_REQ_MAX-1:0] req,
                                        input tag_t start,
                                        input int unsigned n);
    rr_sel_t     sel;
    int unsigned idx;
    sel = '0;
    for (int unsigned k = 0; k < N_REQ_MAX; k++) begin
      idx = 32'(start) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !sel.found && req[idx[W_TAG-1:0]]) begin
        sel.found = 1'b1;
        sel.idx   = idx[W_TAG-1:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rom_arb_tag_fifo.sv
// In-order requester-tag FIFO: registered write, combinational head read.
module rom_arb_tag_fifo
  import rom_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  tag_t                   din,
  input  logic                   pop,
  output tag_t                   dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned W_PTR = $clog2(DEPTH);

  tag_t [DEPTH-1:0] mem_q, mem_d;
  logic [W_PTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [W_PTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [W_PTR:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (W_PTR+1)'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + W_PTR'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + W_PTR'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (W_PTR+1)'(1);
      2'b01:   count_d = count_q - (W_PTR+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin sharing of one rom read port among N_REQ requesters; data is
// steered back in acceptance order using a tag FIFO.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned W_ADDR          = 16,
  parameter int unsigned W_DATA          = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_addr_valid,
  input  logic [N_REQ-1:0][W_ADDR-1:0]  req_addr_data,
  output logic [N_REQ-1:0]              req_addr_ready,
  output logic [N_REQ-1:0]              req_data_valid,
  output logic [N_REQ-1:0][W_DATA-1:0]  req_data_data,
  input  logic [N_REQ-1:0]              req_data_ready,
  output logic                          rom_addr_valid,
  output logic [W_ADDR-1:0]             rom_addr_data,
  input  logic                          rom_addr_ready,
  input  logic                          rom_data_valid,
  input  logic [W_DATA-1:0]             rom_data_data,
  output logic                          rom_data_ready
);

  grant_state_e state_q, state_d;
  tag_t         grant_q, grant_d;
  tag_t         rr_ptr_q, rr_ptr_d;
  tag_t         g;
  rr_sel_t      sel;
  logic         grant_hit, grant_active, addr_hs, data_hs;

  logic [N_REQ_MAX-1:0]             req_vec, aready_vec, dvalid_vec, dready_vec;
  logic [N_REQ_MAX-1:0][W_ADDR-1:0] addr_vec;

  tag_t                            fifo_dout;
  logic                            fifo_empty, fifo_full;
  logic [$clog2(MAX_OUTSTANDING):0] fifo_count_unused;

  always_comb begin
    req_vec                = '0;
    req_vec[N_REQ-1:0]     = req_addr_valid;
    addr_vec               = '0;
    addr_vec[N_REQ-1:0]    = req_addr_data;
    dready_vec             = '0;
    dready_vec[N_REQ-1:0]  = req_data_ready;
    aready_vec             = '0;
    dvalid_vec             = '0;
    state_d                = state_q;
    grant_d                = grant_q;
    rr_ptr_d               = rr_ptr_q;
    g                      = grant_q;
    grant_hit              = 1'b0;
    sel                    = rr_select(req_vec, rr_ptr_q, N_REQ);

    unique case (state_q)
      GRANT_IDLE: begin
        if (!fifo_full && sel.found) begin
          g         = sel.idx;
          grant_hit = 1'b1;
        end
      end
      GRANT_LOCKED: grant_hit = 1'b1;
      default:      grant_hit = 1'b0;
    endcase

    // The IDLE grant is combinational, so reset must mask it to drop outputs at once.
    grant_active   = grant_hit & ~rst;
    rom_addr_valid = grant_active & req_vec[g];
    rom_addr_data  = addr_vec[g];
    aready_vec[g]  = grant_active & rom_addr_ready;
    addr_hs        = rom_addr_valid & rom_addr_ready;

    if (addr_hs) begin
      state_d  = GRANT_IDLE;
      rr_ptr_d = (g == tag_t'(N_REQ-1)) ? '0 : g + tag_t'(1);
    end else if (grant_active) begin
      state_d = GRANT_LOCKED;
      grant_d = g;
    end

    rom_data_ready        = ~fifo_empty & dready_vec[fifo_dout];
    dvalid_vec[fifo_dout] = rom_data_valid & ~fifo_empty;
    data_hs               = rom_data_valid & rom_data_ready;
  end

  assign req_addr_ready = aready_vec[N_REQ-1:0];
  assign req_data_valid = dvalid_vec[N_REQ-1:0];
  assign req_data_data  = {N_REQ{rom_data_data}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= GRANT_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  rom_arb_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (addr_hs),
    .din  (g),
    .pop  (data_hs),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count_unused)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: queue-based requester/rom/ordering model, rr table, directed corners, random traffic.
module tb_rom_arbiter;

  localparam int N = 4, WA = 16, WD = 16, MAXO = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_addr_valid, req_addr_ready, req_data_valid, req_data_ready;
  logic [N-1:0][WA-1:0] req_addr_data;
  logic [N-1:0][WD-1:0] req_data_data;
  logic                 rom_addr_valid, rom_addr_ready, rom_data_valid, rom_data_ready;
  logic [WA-1:0]        rom_addr_data;
  logic [WD-1:0]        rom_data_data;

  rom_arbiter #(.N_REQ(N), .W_ADDR(WA), .W_DATA(WD), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .req_addr_valid(req_addr_valid), .req_addr_data(req_addr_data), .req_addr_ready(req_addr_ready),
    .req_data_valid(req_data_valid), .req_data_data(req_data_data), .req_data_ready(req_data_ready),
    .rom_addr_valid(rom_addr_valid), .rom_addr_data(rom_addr_data), .rom_addr_ready(rom_addr_ready),
    .rom_data_valid(rom_data_valid), .rom_data_data(rom_data_data), .rom_data_ready(rom_data_ready)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  // Environment / reference state
  logic [WA-1:0] rq[N][$];      // pending addresses per requester
  logic [WD-1:0] expq[N][$];    // expected returned data per requester
  logic [WD-1:0] romq[$];       // rom pipeline contents
  int            order[$];      // requester ids in acceptance order
  int            grant_log[$], grant_cyc[$], pop_log[$], pop_cyc[$];
  int            ptr, locked;
  logic          rom_ready_v, rom_stall;
  logic [N-1:0]  dready_v;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    int           w1;
    int           w2;
  } rr_vec_t;

  function automatic logic [WD-1:0] mem(input logic [WA-1:0] a);
    return a * 16'd3 + 16'h1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete(); grant_cyc.delete(); pop_log.delete(); pop_cyc.delete();
  endtask

  task automatic model_clear(input bit clear_req);
    ptr = 0; locked = -1;
    order.delete(); romq.delete();
    for (int i = 0; i < N; i++) begin
      expq[i].delete();
      if (clear_req) rq[i].delete();
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_addr_valid[i] = (rq[i].size() != 0);
      req_addr_data[i]  = (rq[i].size() != 0) ? rq[i][0] : '0;
    end
    rom_addr_ready = rom_ready_v;
    req_data_ready = dready_v;
    rom_data_valid = (romq.size() != 0) && !rom_stall;
    rom_data_data  = (romq.size() != 0) ? romq[0] : '0;
  endtask

  // One cycle: drive at negedge, check just after, commit handshakes, wait for next negedge.
  task automatic step();
    int g, h;
    logic [N-1:0] ea, ev;
    logic eav, edr;
    logic [WD-1:0] d;
    drive();
    #1;
    g = -1; h = -1;
    if (!rst) begin
      if (locked >= 0) g = locked;
      else if (order.size() < MAXO)
        for (int k = 0; k < N; k++)
          if (g < 0 && rq[(ptr + k) % N].size() != 0) g = (ptr + k) % N;
      if (order.size() != 0) h = order[0];
    end
    eav = (g >= 0);
    ea = '0; ev = '0;
    if (g >= 0 && rom_ready_v) ea[g] = 1'b1;
    edr = (h >= 0) && dready_v[h];
    if (h >= 0 && rom_data_valid) ev[h] = 1'b1;
    chk("rom_addr_valid", rom_addr_valid, eav);
    if (eav) chk("rom_addr_data", rom_addr_data, rq[g][0]);
    chk("req_addr_ready", req_addr_ready, ea);
    chk("rom_data_ready", rom_data_ready, edr);
    chk("req_data_valid", req_data_valid, ev);
    if (ev != 0) chk("req_data_data", req_data_data[h], expq[h][0]);
    if (h >= 0 && rom_data_valid && dready_v[h]) begin
      void'(romq.pop_front()); void'(order.pop_front()); void'(expq[h].pop_front());
      pop_log.push_back(h); pop_cyc.push_back(cyc);
    end
    if (g >= 0 && rom_ready_v) begin
      d = mem(rq[g][0]);
      romq.push_back(d); expq[g].push_back(d); order.push_back(g);
      void'(rq[g].pop_front());
      ptr = (g + 1) % N; locked = -1;
      grant_log.push_back(g); grant_cyc.push_back(cyc);
    end else if (g >= 0) begin
      locked = g;
    end
    @(negedge clk);
    cyc++;
  endtask

  function automatic bit busy();
    bit b = (order.size() != 0);
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) b = 1;
    return b;
  endfunction

  task automatic drain(input string name);
    for (int c = 0; c < 300 && busy(); c++) step();
    chk(name, busy(), 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear(1);
    drive();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    rom_ready_v = 1'b1; dready_v = '1; rom_stall = 1'b0;
    clear_logs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_vec_t tbl[7];
    tbl[0] = '{4'b1111, 4'b0000, 0, 1};
    tbl[1] = '{4'b1010, 4'b0000, 1, 3};
    tbl[2] = '{4'b1000, 4'b0001, 3, 0};
    tbl[3] = '{4'b0100, 4'b0011, 2, 0};
    tbl[4] = '{4'b1001, 4'b0000, 0, 3};
    tbl[5] = '{4'b0110, 4'b1000, 1, 2};
    tbl[6] = '{4'b0010, 4'b0001, 1, 0};

    // Reset state: outputs low even with requests pending
    rst = 1'b1; rom_ready_v = 1'b1; dready_v = '1; rom_stall = 1'b0;
    model_clear(1);
    for (int i = 0; i < N; i++) rq[i].push_back(16'(i));
    drive();
    #1;
    chk("reset_rom_addr_valid", rom_addr_valid, 1'b0);
    chk("reset_req_addr_ready", req_addr_ready, '0);
    chk("reset_req_data_valid", req_data_valid, '0);
    chk("reset_rom_data_ready", rom_data_ready, 1'b0);
    do_reset();

    // Round-robin table: first winner from rr_ptr=0, second from winner+1 with wrap
    foreach (tbl[t]) begin
      do_reset();
      for (int i = 0; i < N; i++) if (tbl[t].a[i]) rq[i].push_back(16'h0A00 + 16'(i));
      step();
      for (int i = 0; i < N; i++) if (tbl[t].b[i]) rq[i].push_back(16'h0B00 + 16'(i));
      step();
      chk("rr_tbl_count", grant_log.size(), 2);
      if (grant_log.size() == 2) begin
        chk("rr_tbl_first", grant_log[0], tbl[t].w1);
        chk("rr_tbl_second", grant_log[1], tbl[t].w2);
      end
    end

    // Single requester, back-to-back
    do_reset();
    rq[0].push_back(16'h10); rq[0].push_back(16'h11); rq[0].push_back(16'h12);
    drain("single_drain");
    chk("single_grants", grant_log.size(), 3);
    chk("single_pops", pop_log.size(), 3);
    if (grant_cyc.size() == 3) begin
      chk("single_b2b_1", grant_cyc[1] - grant_cyc[0], 1);
      chk("single_b2b_2", grant_cyc[2] - grant_cyc[1], 1);
    end

    // All requesters continuously valid
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) rq[i].push_back(16'h100 + 16'(i * 16 + k));
    drain("all_drain");
    chk("all_grants", grant_log.size(), 8);
    if (grant_log.size() == 8)
      for (int k = 0; k < 8; k++) chk("all_order", grant_log[k], k % N);

    // Lock held while rom_addr_ready is low
    do_reset();
    rom_ready_v = 1'b0;
    rq[2].push_back(16'h40);
    step();
    rq[1].push_back(16'h50);
    for (int k = 0; k < 5; k++) step();
    chk("lock_no_grant", grant_log.size(), 0);
    rom_ready_v = 1'b1;
    drain("lock_drain");
    chk("lock_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("lock_first", grant_log[0], 2);
      chk("lock_second", grant_log[1], 1);
    end

    // Full: data backpressure on requester 1 with MAXO reads in flight
    do_reset();
    dready_v = 4'b1101;
    for (int k = 0; k < 5; k++) rq[1].push_back(16'h60 + 16'(k));
    for (int k = 0; k < 8; k++) step();
    chk("full_grants", grant_log.size(), MAXO);
    chk("full_pops", pop_log.size(), 0);
    dready_v = '1;
    drain("full_drain");
    chk("full_total", grant_log.size(), 5);
    if (grant_cyc.size() == 5 && pop_cyc.size() != 0)
      chk("full_resume", grant_cyc[4] - pop_cyc[0], 1);

    // Interleaved: requester 3 then 0, data order follows acceptance order
    do_reset();
    dready_v = 4'b0001;
    rq[3].push_back(16'h20);
    step();
    rq[0].push_back(16'h30);
    for (int k = 0; k < 3; k++) step();
    chk("inter_blocked", pop_log.size(), 0);
    dready_v = '1;
    drain("inter_drain");
    chk("inter_pops", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      chk("inter_first", pop_log[0], 3);
      chk("inter_second", pop_log[1], 0);
    end

    // Async reset during a locked grant with two tags in flight
    do_reset();
    dready_v = '0;
    for (int i = 0; i < N; i++) rq[i].push_back(16'h200 + 16'(i));
    step(); step();
    chk("rst_inflight", order.size(), 2);
    rom_ready_v = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_rom_addr_valid", rom_addr_valid, 1'b0);
    chk("rst_async_req_addr_ready", req_addr_ready, '0);
    chk("rst_async_req_data_valid", req_data_valid, '0);
    chk("rst_async_rom_data_ready", rom_data_ready, 1'b0);
    model_clear(0);
    rq[0].push_back(16'h300); rq[1].push_back(16'h301);
    @(negedge clk);
    step();
    rst = 1'b0;
    rom_ready_v = 1'b1; dready_v = '1;
    clear_logs();
    step();
    chk("rst_winner_count", grant_log.size(), 1);
    if (grant_log.size() == 1) chk("rst_winner", grant_log[0], 0);
    drain("rst_drain");

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (rq[i].size() < 2 && $urandom_range(0, 3) == 0) rq[i].push_back(16'($urandom));
      rom_ready_v = ($urandom_range(0, 3) != 0);
      dready_v    = N'($urandom);
      rom_stall   = ($urandom_range(0, 4) == 0);
      step();
    end
    rom_ready_v = 1'b1; dready_v = '1; rom_stall = 1'b0;
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
